// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, requests to send,
// shifts one byte plus odd parity on device clock falls and checks the ACK bit.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int RTS_CYCLES     = 200,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  // state     | meaning
  // IDLE      | lines released, waiting for send
  // INHIBIT   | host holds clock low
  // RTS       | clock and data low (start bit), then clock released
  // SHIFT     | data bits, parity and stop driven on device clock falls
  // ACK       | sample device ACK on the 11th fall
  // WAIT_IDLE | wait for both lines high, then report done/error
  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE
  } state_t;

  localparam int MAX_A   = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int MAX_CYC = (TIMEOUT_CYCLES > MAX_A) ? TIMEOUT_CYCLES : MAX_A;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0] shreg_q, shreg_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic       data_q, data_d;
  logic       ack_ok_q, ack_ok_d;
  logic       done_q, done_d;
  logic       error_q, error_d;

  logic       clk_s1_q, clk_s2_q, clk_prev_q;
  logic       data_s1_q, data_s2_q;
  logic       fall;
  logic       tc;

  // Synchronisers idle high so reset never fakes a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2_data_in;
      data_s2_q  <= data_s1_q;
    end
  end

  assign fall = clk_prev_q & ~clk_s2_q;
  assign tc   = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      data_q   <= 1'b0;
      ack_ok_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      data_q   <= data_d;
      ack_ok_q <= ack_ok_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    data_d   = data_q;
    ack_ok_d = ack_ok_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    case (state_q)
      IDLE: begin
        data_d = 1'b0;
        if (send) begin
          shreg_d = {~^din, din};
          cnt_d   = CNT_W'(INHIBIT_CYCLES - 1);
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        if (tc) begin
          cnt_d   = CNT_W'(RTS_CYCLES - 1);
          state_d = RTS;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RTS: begin
        if (tc) begin
          cnt_d    = CNT_W'(TIMEOUT_CYCLES - 1);
          bitcnt_d = '0;
          data_d   = 1'b1;
          state_d  = SHIFT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SHIFT, ACK, WAIT_IDLE: begin
        // Timeout wins over any device activity in the same cycle.
        if (tc) begin
          data_d  = 1'b0;
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (state_q == SHIFT && fall) begin
            if (bitcnt_q == 4'd9) begin
              data_d  = 1'b0;
              state_d = ACK;
            end else begin
              data_d   = ~shreg_q[0];
              shreg_d  = {1'b0, shreg_q[8:1]};
              bitcnt_d = bitcnt_q + 4'd1;
            end
          end else if (state_q == ACK && fall) begin
            ack_ok_d = ~data_s2_q;
            state_d  = WAIT_IDLE;
          end else if (state_q == WAIT_IDLE && clk_s2_q && data_s2_q) begin
            done_d  = ack_ok_q;
            error_d = ~ack_ok_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign error       = error_q;
  assign ps2_clk_oe  = (state_q == INHIBIT) || (state_q == RTS);
  assign ps2_data_oe = (state_q == RTS) || ((state_q == SHIFT) && data_q);

endmodule
